// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle RV32I control path.
//   - RV32I major opcodes (also used by the immediate generator)
//   - control FSM state encoding
//   - datapath mux encodings: pc_src, wb_sel, alu_a_sel, alu_b_sel, alu_op
//   - trap cause codes
//   - alu_ctl(): ALU operand/operation selection for a given opcode
package cpu_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [2:0] F3_ECALL = 3'b000;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_IMM = 2'b01, PC_ALU = 2'b10} pc_src_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_e;
  typedef enum logic [1:0] {A_RS1 = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10} alu_a_e;
  typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_b_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_CMP = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;

  typedef struct packed {
    alu_a_e  a;
    alu_b_e  b;
    alu_op_e op;
  } alu_ctl_t;

  // Operand selection held from EXEC through WB so the ALU result stays valid
  // while memory or the register file consumes it.
  function automatic alu_ctl_t alu_ctl(input logic [6:0] opcode);
    alu_ctl_t c;
    c.a  = A_RS1;
    c.b  = B_RS2;
    c.op = ALU_ADD;
    case (opcode)
      OP_R:                 c.op = ALU_FUNCT;
      OP_I: begin
        c.b  = B_IMM;
        c.op = ALU_FUNCT;
      end
      OP_L, OP_S, OP_JALR:  c.b = B_IMM;
      OP_B:                 c.op = ALU_CMP;
      OP_J: begin
        c.a = A_PC;
        c.b = B_FOUR;
      end
      OP_LUI: begin
        c.a = A_ZERO;
        c.b = B_IMM;
      end
      OP_AUIPC: begin
        c.a = A_PC;
        c.b = B_IMM;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_ack_timer.sv
// mem_ack_timer: counts cycles a memory request has been waiting for its ack.
//   clk        system clock
//   rst_n      synchronous active-low reset
//   start_i    high for every cycle a request is presented
//   ack_i      memory completion
//   expired_o  request has been waiting ACK_TIMEOUT cycles with no ack this cycle
// The count is zero in the first cycle of each request, so expiry fires in the
// ACK_TIMEOUT-th waiting cycle; an ack in that cycle suppresses it.
module mem_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = start_i && !ack_i;

  always_comb begin
    cnt_d = '0;
    if (waiting) begin
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = waiting && (cnt_q == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control FSM sequencing one shared memory port,
// the ALU, register file and immediate generator.
//   clk, rst_n            clock, synchronous active-low reset
//   opcode, funct3        instruction register fields
//   br_taken              branch compare result (EXEC)
//   mem_ack               memory completion
//   mem_req, mem_we       memory request / store
//   addr_sel              0 = PC, 1 = ALU result
//   ir_we, pc_we, pc_src  IR / PC update controls
//   alu_a_sel, alu_b_sel, alu_op   ALU operand and operation selects
//   rf_we, wb_sel         register-file write enable and source
//   halted, trap, trap_cause       sticky terminal status
//   instret               retired-instruction count (wraps)
//
// state  | meaning
// FETCH  | read instruction at PC, wait for ack, latch IR and PC+4
// DECODE | ALU forms branch target PC+imm
// EXEC   | execute by opcode class; branches resolve here
// MEM    | load/store data access at ALU address
// WB     | one-cycle register-file write
// HALT   | ecall seen; idle until reset
// TRAP   | illegal opcode or bus timeout; idle until reset
//
// The cycle after reset is idle (run_q = 0) so a request in flight at the
// reset edge drops immediately and any late ack is ignored.
module mc_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             run_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             req_active;
  logic             expired;
  alu_ctl_t         ctl;

  assign req_active = run_q && ((state_q == S_FETCH) || (state_q == S_MEM));

  mem_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (req_active),
    .ack_i    (mem_ack),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    halted    = 1'b0;
    trap      = 1'b0;
    ctl       = alu_ctl(opcode);

    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req = req_active;
          if (mem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end else if (expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
          end
        end

        S_DECODE: begin
          alu_a_sel = A_PC;
          alu_b_sel = B_IMM;
          state_d   = S_EXEC;
        end

        S_EXEC: begin
          alu_a_sel = ctl.a;
          alu_b_sel = ctl.b;
          alu_op    = ctl.op;
          state_d   = S_WB;
          case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: ;
            OP_L, OP_S: state_d = S_MEM;
            OP_B: begin
              pc_we     = br_taken;
              pc_src    = PC_IMM;
              instret_d = instret_q + ONE;
              state_d   = S_FETCH;
            end
            OP_J: begin
              pc_we  = 1'b1;
              pc_src = PC_IMM;
            end
            OP_JALR: begin
              pc_we  = 1'b1;
              pc_src = PC_ALU;
            end
            OP_SYS: begin
              if (funct3 == F3_ECALL) begin
                state_d = S_HALT;
              end else begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
              end
            end
            default: begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end

        S_MEM: begin
          mem_req   = req_active;
          addr_sel  = 1'b1;
          mem_we    = (opcode == OP_S);
          alu_a_sel = ctl.a;
          alu_b_sel = ctl.b;
          alu_op    = ctl.op;
          if (mem_ack) begin
            if (opcode == OP_S) begin
              instret_d = instret_q + ONE;
              state_d   = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (expired) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
          end
        end

        S_WB: begin
          alu_a_sel = ctl.a;
          alu_b_sel = ctl.b;
          alu_op    = ctl.op;
          rf_we     = 1'b1;
          if (opcode == OP_L) begin
            wb_sel = WB_MEM;
          end else if ((opcode == OP_J) || (opcode == OP_JALR)) begin
            wb_sel = WB_PC4;
          end
          instret_d = instret_q + ONE;
          state_d   = S_FETCH;
        end

        S_HALT: halted = 1'b1;
        S_TRAP: trap = 1'b1;
        default: begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  localparam int TMO = 4;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] OPL   = 7'b0000011;
  localparam logic [6:0] OPS   = 7'b0100011;
  localparam logic [6:0] OPB   = 7'b1100011;
  localparam logic [6:0] OPJ   = 7'b1101111;
  localparam logic [6:0] OPJR  = 7'b1100111;
  localparam logic [6:0] OPLUI = 7'b0110111;
  localparam logic [6:0] OPAUI = 7'b0010111;
  localparam logic [6:0] OPSYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        br_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, halted, trap;
  logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel, trap_cause;
  logic [31:0] instret;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ACK_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .br_taken(br_taken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  // Leaves the bench at a falling edge with the DUT running in FETCH.
  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_instret = 32'd0;
  endtask

  task automatic test_reset();
    logic any_en;
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    any_en = mem_req | mem_we | ir_we | pc_we | rf_we | halted | trap;
    vectors++;
    if (any_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0", any_en);
    end
    vectors++;
    if (instret !== 32'd0 || trap_cause !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_regs: instret %0d cause %b want 0/00", instret, trap_cause);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || addr_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fetch: mem_req %b addr_sel %b want 1/0", mem_req, addr_sel);
    end
    exp_instret = 32'd0;
  endtask

  // Runs one instruction from its first FETCH cycle; wf/wm are the number of
  // request cycles without ack before the fetch/data ack arrives.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input logic taken);
    bit is_l, is_s, is_b, is_jmp, is_jr, writes;
    int ncyc, exp_req, exp_we, exp_pc, burst, wcnt;
    int n_req, n_we, n_ir, n_rf, n_pc, n_stray, n_fsrc;
    logic [1:0] exp_wb, exp_src, got_wb, got_src;
    logic prev_req;
    is_l   = (op == OPL);
    is_s   = (op == OPS);
    is_b   = (op == OPB);
    is_jr  = (op == OPJR);
    is_jmp = (op == OPJ) || is_jr;
    writes = !(is_b || is_s);
    ncyc    = (1 + wf) + 2 + ((is_l || is_s) ? 1 + wm : 0) + (writes ? 1 : 0);
    exp_req = (1 + wf) + ((is_l || is_s) ? 1 + wm : 0);
    exp_we  = is_s ? 1 + wm : 0;
    exp_pc  = 1 + ((is_b && taken) ? 1 : 0) + (is_jmp ? 1 : 0);
    exp_wb  = is_l ? 2'b01 : (is_jmp ? 2'b10 : 2'b00);
    exp_src = is_jr ? 2'b10 : 2'b01;
    opcode   = op;
    funct3   = 3'($urandom_range(0, 7));
    br_taken = taken;
    n_req = 0; n_we = 0; n_ir = 0; n_rf = 0; n_pc = 0; n_stray = 0; n_fsrc = 0;
    burst = 0; wcnt = 0; prev_req = 1'b0;
    got_wb = 2'b11; got_src = 2'b11;
    for (int c = 0; c < ncyc; c++) begin
      if (mem_req) begin
        if (!prev_req) begin
          burst++;
          wcnt = 0;
        end
        mem_ack = (wcnt == ((burst <= 1) ? wf : wm));
        wcnt++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      prev_req = mem_req;
      #1;
      n_req += int'(mem_req);
      n_we  += int'(mem_req & mem_we);
      n_ir  += int'(ir_we);
      n_rf  += int'(rf_we);
      n_pc  += int'(pc_we);
      n_stray += int'(trap | halted);
      if (ir_we && pc_src !== 2'b00) n_fsrc++;
      if (rf_we) got_wb = wb_sel;
      if (pc_we && !ir_we) got_src = pc_src;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    exp_instret = exp_instret + 32'd1;

    vectors++;
    if (n_req !== exp_req) begin
      miscompares++;
      $display("FAIL req_cycles op=%b: got %0d want %0d", op, n_req, exp_req);
    end
    vectors++;
    if (n_we !== exp_we) begin
      miscompares++;
      $display("FAIL store_cycles op=%b: got %0d want %0d", op, n_we, exp_we);
    end
    vectors++;
    if (n_ir !== 1 || n_fsrc !== 0) begin
      miscompares++;
      $display("FAIL ir_we op=%b: pulses %0d bad_src %0d want 1/0", op, n_ir, n_fsrc);
    end
    vectors++;
    if (n_rf !== (writes ? 1 : 0)) begin
      miscompares++;
      $display("FAIL rf_we op=%b: pulses %0d want %0d", op, n_rf, writes ? 1 : 0);
    end
    if (writes) begin
      vectors++;
      if (got_wb !== exp_wb) begin
        miscompares++;
        $display("FAIL wb_sel op=%b: got %b want %b", op, got_wb, exp_wb);
      end
    end
    vectors++;
    if (n_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL pc_we op=%b taken=%b: pulses %0d want %0d", op, taken, n_pc, exp_pc);
    end
    if (exp_pc > 1) begin
      vectors++;
      if (got_src !== exp_src) begin
        miscompares++;
        $display("FAIL pc_src op=%b: got %b want %b", op, got_src, exp_src);
      end
    end
    vectors++;
    if (n_stray !== 0) begin
      miscompares++;
      $display("FAIL stray_status op=%b: %0d cycles with trap/halted", op, n_stray);
    end
    vectors++;
    if (instret !== exp_instret || mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL retire op=%b: instret %0d next_req %b want %0d/1", op, instret, mem_req, exp_instret);
    end
  endtask

  task automatic test_r_type();
    run_instr(OPR, 1, 0, 1'b0);
  endtask

  task automatic test_load();
    run_instr(OPL, 3, 2, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(OPB, 0, 0, 1'b1);
    run_instr(OPB, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    ops = '{OPR, OPI, OPL, OPS, OPB, OPJ, OPJR, OPLUI, OPAUI};
    for (int k = 0; k < 40; k++) begin
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)));
    end
  endtask

  // Terminal-state check: F, D, E, then 20 idle cycles with random acks.
  task automatic test_terminal(input logic [6:0] op, input logic [2:0] f3,
                               input logic exp_trap, input logic [1:0] exp_cause);
    int n_en;
    do_reset();
    opcode = op;
    funct3 = f3;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_en = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      n_en += int'(mem_req | mem_we | ir_we | pc_we | rf_we);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    vectors++;
    if (trap !== exp_trap || halted !== !exp_trap) begin
      miscompares++;
      $display("FAIL terminal op=%b f3=%b: trap %b halted %b want %b/%b", op, f3, trap, halted, exp_trap, !exp_trap);
    end
    vectors++;
    if (trap_cause !== exp_cause) begin
      miscompares++;
      $display("FAIL trap_cause op=%b f3=%b: got %b want %b", op, f3, trap_cause, exp_cause);
    end
    vectors++;
    if (n_en !== 0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL terminal_idle op=%b: enable cycles %0d instret %0d want 0/0", op, n_en, instret);
    end
  endtask

  task automatic test_timeout();
    int n_req, n_early;
    do_reset();
    opcode = OPR;
    n_req = 0;
    n_early = 0;
    for (int c = 0; c < TMO; c++) begin
      mem_ack = 1'b0;
      #1;
      n_req += int'(mem_req);
      n_early += int'(trap);
      @(negedge clk);
    end
    vectors++;
    if (n_req !== TMO || n_early !== 0) begin
      miscompares++;
      $display("FAIL timeout_wait: req cycles %0d early trap %0d want %0d/0", n_req, n_early, TMO);
    end
    vectors++;
    if (trap !== 1'b1 || trap_cause !== 2'b10 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_trap: trap %b cause %b req %b want 1/10/0", trap, trap_cause, mem_req);
    end
    do_reset();
    run_instr(OPR, TMO - 1, 0, 1'b0);
    vectors++;
    if (trap !== 1'b0 || trap_cause !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_ack_wins: trap %b cause %b want 0/00", trap, trap_cause);
    end
  endtask

  task automatic test_reset_mid_store();
    run_instr(OPR, 0, 0, 1'b0);
    opcode = OPS;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || addr_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL store_wait: req %b we %b addr_sel %b want 1/1/1", mem_req, mem_we, addr_sel);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_store: req %b we %b instret %0d want 0/0/0", mem_req, mem_we, instret);
    end
    rst_n = 1'b1;
    mem_ack = 1'b1;
    #1;
    vectors++;
    if ((ir_we | pc_we | rf_we | mem_we) !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack: ir %b pc %b rf %b we %b want all 0", ir_we, pc_we, rf_we, mem_we);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL restart_fetch: req %b instret %0d want 1/0", mem_req, instret);
    end
    exp_instret = 32'd0;
    run_instr(OPI, 0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_load();
    test_branch();
    test_random();
    test_reset_mid_store();
    test_terminal(7'b1111111, 3'b000, 1'b1, 2'b01);
    test_terminal(OPSYS, 3'($urandom_range(1, 7)), 1'b1, 2'b01);
    test_terminal(OPSYS, 3'b000, 1'b0, 2'b00);
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
